// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_arbiter
// Description : Round-robin arbiter/sequencer sharing one binary-to-BCD
//               converter among N_REQ requesters, with a timeout path for a
//               converter that never completes.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [16*N_REQ-1:0]      data_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic [19:0]              result_o,
  output logic [$clog2(N_REQ)-1:0] result_id_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     conv_en_o,
  output logic [15:0]              conv_data_o,
  input  logic [19:0]              conv_data_i,
  input  logic                     conv_rdy_i
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SUM_W = ID_W + 1;

  // The counter is compared against TIMEOUT-1 so the ACK transition lands
  // on the edge at which it would reach TIMEOUT (no 17-bit overflow needed).
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_CLR = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_COOL     = 3'd5;

  logic [2:0]         state;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    ptr;
  logic [15:0]        cnt;
  logic               cool;
  logic               timed_out;

  logic [15:0]        operand [N_REQ];
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    offset;
  logic [SUM_W-1:0]   sel_sum;
  logic [ID_W-1:0]    sel;

  // Unpack the flat operand bus into one word per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_operand
    assign operand[g] = data_i[16*g +: 16];
  end

  // Circular priority search: rotate requests so bit 0 is the requester at
  // ptr, take the lowest set bit, then map the offset back to an index.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = N_REQ'(req_dbl >> ptr);
    offset  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = ID_W'(i);
    end
    sel_sum = {1'b0, ptr} + {1'b0, offset};
    if (sel_sum >= SUM_W'(N_REQ)) sel_sum = sel_sum - SUM_W'(N_REQ);
    sel = sel_sum[ID_W-1:0];
  end

  // Outputs decoded straight from the state so reset clears them at once.
  assign busy_o    = (state != S_IDLE);
  assign conv_en_o = (state == S_START);
  assign ack_o     = (state == S_ACK) ? (N_REQ'(1) << grant) : '0;
  assign err_o     = (state == S_ACK) && timed_out;

  // Sequencer: grant, start, wait for ready edge pair, acknowledge, cool down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      cool        <= 1'b0;
      timed_out   <= 1'b0;
      result_o    <= '0;
      result_id_o <= '0;
      conv_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            grant       <= sel;
            conv_data_o <= operand[sel];
            cnt         <= '0;
            state       <= S_START;
          end
        end
        S_START, S_WAIT_CLR, S_WAIT_RDY: begin
          cnt <= cnt + 16'd1;
          // A genuine completion wins over a timeout on the same edge.
          if (state == S_WAIT_RDY && conv_rdy_i) begin
            result_o    <= conv_data_i;
            result_id_o <= grant;
            timed_out   <= 1'b0;
            state       <= S_ACK;
          end else if (cnt == TO_LAST) begin
            result_o    <= '0;
            result_id_o <= grant;
            timed_out   <= 1'b1;
            state       <= S_ACK;
          end else if (state == S_START) begin
            state <= S_WAIT_CLR;
          end else if (state == S_WAIT_CLR && !conv_rdy_i) begin
            state <= S_WAIT_RDY;
          end
        end
        S_ACK: begin
          ptr   <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
          cool  <= 1'b0;
          state <= S_COOL;
        end
        S_COOL: begin
          // Two cycles here let the converter finish its post-ready busy tail.
          if (cool) state <= S_IDLE;
          else      cool  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_conv_arbiter
// Description : Self-checking bench for bcd_conv_arbiter with a behavioural
//               converter and an arithmetic round-robin/BCD reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

  localparam int N        = 4;
  localparam int TO       = 200;
  localparam int CONV_LAT = 99;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [16*N-1:0] data_i;
  logic [N-1:0]    ack_o;
  logic [19:0]     result_o;
  logic [1:0]      result_id_o;
  logic            err_o;
  logic            busy_o;
  logic            conv_en_o;
  logic [15:0]     conv_data_o;
  logic [19:0]     conv_data_i = '0;
  logic            conv_rdy_i = 1'b1;

  int nvec = 0;
  int nmis = 0;
  int ptr_m = 0;
  logic [15:0] ops [N];
  logic [N-1:0] pend;

  typedef struct {
    int          idx;
    logic [15:0] op;
    logic [19:0] exp_res;
  } vec_t;
  vec_t tbl [6];

  bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .result_o    (result_o),
    .result_id_o (result_id_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .conv_en_o   (conv_en_o),
    .conv_data_o (conv_data_o),
    .conv_data_i (conv_data_i),
    .conv_rdy_i  (conv_rdy_i)
  );

  always #5 clk = ~clk;

  // Decimal digits computed with plain division.
  function automatic logic [19:0] ref_bcd(input int v);
    int d = 1;
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  // First pending requester at or after p, searching circularly.
  function automatic int first_from(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural converter: ready falls after an accepted start, rises after
  // CONV_LAT cycles with the BCD of the operand, busy for 2 more cycles.
  logic stuck = 1'b0;
  int cv_cnt = 0;
  int cv_tail = 0;
  logic [15:0] cv_op = '0;
  always @(posedge clk) begin
    if (stuck) begin
      conv_rdy_i <= 1'b1;
    end else begin
      if (cv_tail > 0) cv_tail <= cv_tail - 1;
      if (cv_cnt > 0) begin
        if (cv_cnt == 1) begin
          conv_rdy_i  <= 1'b1;
          conv_data_i <= ref_bcd(int'(cv_op));
          cv_tail     <= 2;
        end
        cv_cnt <= cv_cnt - 1;
      end else if (conv_en_o && cv_tail == 0) begin
        conv_rdy_i <= 1'b0;
        cv_op      <= conv_data_o;
        cv_cnt     <= CONV_LAT;
      end
    end
  end

  // Start pulses must be single-cycle and at least 100 cycles apart.
  int cyc = 0;
  int last_en = -1000;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (conv_en_o) begin
      chk("conv_en single cycle", 32'(prev_en), 0);
      if (!prev_en) begin
        chk("conv_en spacing", 32'((cyc - last_en) >= 100), 1);
        last_en = cyc;
      end
    end
    prev_en = conv_en_o;
    cyc = cyc + 1;
  end

  task automatic raise(input int k, input logic [15:0] op);
    ops[k] = op;
    data_i[16*k +: 16] = op;
    req_i[k] = 1'b1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy_o && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("idle reached", 32'(busy_o), 0);
  endtask

  // Raise a request while idle and check the start one cycle later.
  task automatic issue(input int k, input logic [15:0] op);
    raise(k, op);
    @(negedge clk);
    chk("start pulse", 32'(conv_en_o), 1);
    chk("conv_data_o", 32'(conv_data_o), 32'(op));
  endtask

  task automatic serve_one(input int id, input logic [19:0] exp_res, input logic exp_err, input bit drop);
    int w = 0;
    while (ack_o == '0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("ack arrival", 32'(ack_o != '0), 1);
    chk("ack_o", 32'(ack_o), 32'(1 << id));
    chk("result_id_o", 32'(result_id_o), 32'(id));
    chk("result_o", 32'(result_o), 32'(exp_res));
    chk("err_o", 32'(err_o), 32'(exp_err));
    if (drop) req_i[id] = 1'b0;
    ptr_m = (id + 1) % N;
    @(negedge clk);
    chk("ack one cycle", 32'(ack_o), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int t;
    int id;
    int k2;
    logic [3:0] nw;

    tbl[0] = '{0, 16'd4660,  20'h04660};
    tbl[1] = '{2, 16'd0,     20'h00000};
    tbl[2] = '{2, 16'd65535, 20'h65535};
    tbl[3] = '{3, 16'd9999,  20'h09999};
    tbl[4] = '{1, 16'd10,    20'h00010};
    tbl[5] = '{0, 16'd1000,  20'h01000};

    rst = 1'b1;
    req_i = '0;
    data_i = '0;
    pend = '0;
    repeat (3) @(negedge clk);
    chk("reset ack_o", 32'(ack_o), 0);
    chk("reset busy_o", 32'(busy_o), 0);
    chk("reset conv_en_o", 32'(conv_en_o), 0);
    chk("reset result_o", 32'(result_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin with everyone requesting from ptr 0.
    for (int k = 0; k < N; k++) raise(k, 16'(k + 1));
    serve_one(0, 20'h00001, 1'b0, 1'b0);
    serve_one(1, 20'h00002, 1'b0, 1'b0);
    serve_one(2, 20'h00003, 1'b0, 1'b0);
    serve_one(3, 20'h00004, 1'b0, 1'b0);
    serve_one(0, 20'h00001, 1'b0, 1'b1);
    req_i = '0;

    // Single-requester vectors including boundary operands.
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      issue(tbl[v].idx, tbl[v].op);
      serve_one(tbl[v].idx, tbl[v].exp_res, 1'b0, 1'b1);
    end

    // Late arrival on 3 during 1's conversion beats a newly raised 0.
    wait_idle();
    issue(1, 16'd77);
    repeat (30) @(negedge clk);
    raise(3, 16'd333);
    serve_one(1, 20'h00077, 1'b0, 1'b1);
    raise(0, 16'd5);
    serve_one(3, 20'h00333, 1'b0, 1'b1);
    serve_one(0, 20'h00005, 1'b0, 1'b1);

    // Stuck converter: timeout exactly TO cycles after START.
    wait_idle();
    stuck = 1'b1;
    issue(2, 16'd1234);
    t = 0;
    while (ack_o == '0 && t < TO + 50) begin
      @(negedge clk);
      t++;
    end
    chk("timeout latency", 32'(t), 32'(TO));
    serve_one(2, 20'h00000, 1'b1, 1'b1);
    stuck = 1'b0;
    wait_idle();
    issue(2, 16'd42);
    serve_one(2, 20'h00042, 1'b0, 1'b1);

    // Reset in the middle of WAIT_RDY; ptr was 3 beforehand.
    wait_idle();
    issue(2, 16'd555);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-reset ack_o", 32'(ack_o), 0);
    chk("mid-reset busy_o", 32'(busy_o), 0);
    chk("mid-reset conv_en_o", 32'(conv_en_o), 0);
    chk("mid-reset result_o", 32'(result_o), 0);
    chk("mid-reset result_id_o", 32'(result_id_o), 0);
    chk("mid-reset err_o", 32'(err_o), 0);
    chk("mid-reset conv_data_o", 32'(conv_data_o), 0);
    req_i = '0;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    repeat (110) @(negedge clk);
    raise(1, 16'd2024);
    raise(3, 16'd3);
    @(negedge clk);
    chk("post-reset start", 32'(conv_en_o), 1);
    chk("post-reset operand", 32'(conv_data_o), 32'd2024);
    serve_one(1, 20'h02024, 1'b0, 1'b1);
    serve_one(3, 20'h00003, 1'b0, 1'b1);

    // Random traffic against the arithmetic round-robin model.
    pend = '0;
    for (int r = 0; r < 12; r++) begin
      nw = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        if (nw[k] && !pend[k]) begin
          raise(k, 16'($urandom));
          pend[k] = 1'b1;
        end
      end
      while (pend != '0) begin
        id = first_from(pend, ptr_m);
        serve_one(id, ref_bcd(int'(ops[id])), 1'b0, 1'b1);
        pend[id] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          k2 = int'($urandom_range(0, N - 1));
          if (!pend[k2]) begin
            raise(k2, 16'($urandom));
            pend[k2] = 1'b1;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-BCD converter among `N_REQ` requesters. It grants one requester at a time, starts the converter with that requester's 16-bit value, waits for completion, returns the 20-bit BCD result with a one-cycle acknowledge, and recovers through a timeout if the converter never completes. It sits between the display/value sources and the single converter instance.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `TIMEOUT`, 255: maximum cycles from start to converter ready before the conversion is aborted, range 128..65535.
- `clk`  in  1  system clock; everything is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i`  in  N_REQ  per-requester request level.
- `data_i`  in  16*N_REQ  operands; requester k uses bits [16k+15:16k].
- `ack_o`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `result_o`  out  20  BCD result, 5 digits, most significant digit in [19:16].
- `result_id_o`  out  clog2(N_REQ)  index of the requester that owns `result_o`.
- `err_o`  out  1  pulses together with `ack_o` when the conversion timed out.
- `busy_o`  out  1  high in every state except IDLE.
- `conv_en_o`  out  1  converter start, one-cycle pulse.
- `conv_data_o`  out  16  operand to the converter.
- `conv_data_i`  in  20  converter result.
- `conv_rdy_i`  in  1  converter ready level.

## Operation
**Requester contract**
- A requester raises `req_i[k]` with its operand stable, and holds both until `ack_o[k]`.
- Dropping `req_i[k]` early is a protocol violation. The arbiter still completes the conversion and still pulses `ack_o[k]`.

**Converter contract**
- The converter accepts `conv_en_o` only while it is internally idle.
- `conv_rdy_i` falls within 2 cycles of an accepted start.
- `conv_rdy_i` rises about 99 cycles after the start and stays high until the next accepted start.
- The converter stays internally busy for up to 2 cycles after `conv_rdy_i` rises.

**State machine** (IDLE, START, WAIT_CLR, WAIT_RDY, ACK, COOL)
- **IDLE**
  - If any `req_i` bit is high, select the first requesting index at or after `ptr`, searching circularly.
  - Latch that index into the grant register and latch its operand into `conv_data_o`.
  - Clear the timeout counter and go to START.
- **START**
  - `conv_en_o`=1 for exactly this cycle; go to WAIT_CLR.
- **WAIT_CLR**
  - Wait for `conv_rdy_i`=0, then go to WAIT_RDY.
- **WAIT_RDY**
  - Wait for `conv_rdy_i`=1, then capture `conv_data_i` into `result_o` and go to ACK.
- **ACK**
  - `ack_o[grant]`=1 and `result_id_o`=grant.
  - Set `ptr` to (grant+1) mod N_REQ; go to COOL.
- **COOL**
  - Hold exactly 2 cycles, then go to IDLE.
- **Timeout**
  - The counter increments in START, WAIT_CLR and WAIT_RDY.
  - When it reaches TIMEOUT, the arbiter goes to ACK with `result_o`=0 and `err_o`=1 during ACK.

**Outputs**
- `result_o` and `result_id_o` hold their values until the next ACK.
- `conv_data_o` holds its value until the next grant.
- `ptr` starts at 0 after reset.

**Reset** (asserted at any time, including mid-conversion)
- All outputs go to 0, state goes to IDLE, `ptr` goes to 0, and the counter clears.
- The converter is not reset by this block. A start issued while the converter is still busy is covered by the timeout path.

## Timing
- A request seen in IDLE at edge n gives `conv_en_o` high in cycle n+1.
- `ack_o` is high in the cycle after the edge at which WAIT_RDY sees `conv_rdy_i`=1. That is about 102 cycles from grant with a nominal converter.
- Minimum spacing between successive `conv_en_o` pulses is nominal latency + 5 cycles (ACK, 2×COOL, IDLE, START).
- Requests that arrive while busy wait; they are never dropped.
- A `req_i` change in the same cycle as ACK affects arbitration only at the next IDLE.
- With every requester continuously requesting, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 conversions.

## Test plan
- **Single request:** `req_i`=0001, operand0=16'd4660 → one `conv_en_o` pulse, then `ack_o`=0001, `result_o`=20'h04660, `result_id_o`=0, `err_o`=0.
- **Boundary operands:** on requester 2, operand 16'd0 → `result_o`=20'h00000; operand 16'd65535 → `result_o`=20'h65535.
- **Round robin:** all four requesters held high with operands 1, 2, 3, 4 → `ack_o` order 0,1,2,3,0 with results 20'h00001..20'h00004. No two `conv_en_o` pulses are closer than 100 cycles.
- **Late arrival:** a request on index 3 arrives mid-conversion of index 1 → index 3 is served next, ahead of a newly raised index 0.
- **Stuck converter** (model holds `conv_rdy_i`=1 and ignores start) → exactly TIMEOUT cycles after START, `ack_o`[k]=1, `err_o`=1, `result_o`=0; the next request then proceeds normally.
- **Reset mid-WAIT_RDY:** assert `rst` for 1 cycle → all outputs are 0 immediately. The following request on index 1 is granted first and completes with the correct result.
